// File: rtl/digclock_pkg.sv
// ============================================================================
//  digclock_pkg
//  Seven-segment glyph constants and display page state encoding.
//  Rev 1.0
// ============================================================================
`default_nettype none

package digclock_pkg;

   localparam logic [6:0] C_SEG_0     = 7'h40;
   localparam logic [6:0] C_SEG_1     = 7'h79;
   localparam logic [6:0] C_SEG_2     = 7'h24;
   localparam logic [6:0] C_SEG_3     = 7'h30;
   localparam logic [6:0] C_SEG_4     = 7'h19;
   localparam logic [6:0] C_SEG_5     = 7'h12;
   localparam logic [6:0] C_SEG_6     = 7'h02;
   localparam logic [6:0] C_SEG_7     = 7'h78;
   localparam logic [6:0] C_SEG_8     = 7'h00;
   localparam logic [6:0] C_SEG_9     = 7'h10;
   localparam logic [6:0] C_SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      SHOW_TIME = 1'b0,
      SHOW_DATE = 1'b1
   } page_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
//  bcd_to_seg7
//  Combinational BCD nibble to active-low seven-segment decoder.
//  Rev 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg7
   import digclock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = C_SEG_0;
         4'd1:    seg = C_SEG_1;
         4'd2:    seg = C_SEG_2;
         4'd3:    seg = C_SEG_3;
         4'd4:    seg = C_SEG_4;
         4'd5:    seg = C_SEG_5;
         4'd6:    seg = C_SEG_6;
         4'd7:    seg = C_SEG_7;
         4'd8:    seg = C_SEG_8;
         4'd9:    seg = C_SEG_9;
         default: seg = C_SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/hex_pager.sv
// ============================================================================
//  hex_pager
//  Time/date page selection, edit-mode digit blinking and 8-digit HEX drive.
//  Rev 1.0
// ============================================================================
`default_nettype none

module hex_pager
   import digclock_pkg::*;
#(
   parameter int BLINK_DIV     = 12_500_000,
   parameter int TIMEOUT_TICKS = 40
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       adjust,
   input  logic [3:0] select,
   input  logic       page_key,
   input  logic [7:0] millisecond,
   input  logic [6:0] second,
   input  logic [6:0] minute,
   input  logic [5:0] hour,
   input  logic [5:0] day,
   input  logic [4:0] month,
   input  logic [7:0] year_l,
   input  logic [7:0] year_h,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [6:0] HEX6,
   output logic [6:0] HEX7,
   output logic       page
);

   localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [PW-1:0] C_PRESC_LAST = PW'(BLINK_DIV - 1);
   localparam logic [TW-1:0] C_TMO_LAST   = TW'(TIMEOUT_TICKS - 1);

   page_state_t   r_state, w_state_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [TW-1:0] r_tmo, w_tmo_nxt;
   logic          r_blink_on, w_blink_nxt;
   logic          r_key_prev, r_adjust_prev;
   logic [3:0]    r_select_prev;
   logic          r_page, w_page_nxt;
   logic [6:0]    r_hex [8];
   logic [3:0]    w_nib [8];
   logic [6:0]    w_seg [8];
   logic [7:0]    w_blank;
   logic          w_tick, w_key_edge, w_sel_change;

   assign w_tick       = (r_presc == C_PRESC_LAST);
   assign w_key_edge   = page_key & ~r_key_prev;
   assign w_sel_change = ~adjust & (select != r_select_prev);

   // Outputs are registered from next-state values so every input reaches
   // the display in exactly one clock.
   always_comb begin
      w_presc_nxt = r_presc + 1'b1;
      w_blink_nxt = r_blink_on;
      w_state_nxt = r_state;
      w_tmo_nxt   = r_tmo;
      if (w_sel_change) begin
         w_presc_nxt = '0;
         w_blink_nxt = 1'b1;
      end else if (w_tick) begin
         w_presc_nxt = '0;
         w_blink_nxt = ~r_blink_on;
      end
      if (!adjust) begin
         w_tmo_nxt = '0;
      end else if (!r_adjust_prev) begin
         w_state_nxt = SHOW_TIME;
         w_tmo_nxt   = '0;
      end else if (r_state == SHOW_DATE) begin
         if (w_tick && (r_tmo == C_TMO_LAST)) begin
            w_state_nxt = SHOW_TIME;
            w_tmo_nxt   = '0;
         end else begin
            if (w_tick) w_tmo_nxt = r_tmo + 1'b1;
            if (w_key_edge) w_state_nxt = SHOW_TIME;
         end
      end else if (w_key_edge) begin
         w_state_nxt = SHOW_DATE;
         w_tmo_nxt   = '0;
      end
      w_page_nxt = adjust ? (w_state_nxt == SHOW_DATE) : select[3];
   end

   always_comb begin
      if (w_page_nxt) begin
         w_nib[7] = year_h[7:4];
         w_nib[6] = year_h[3:0];
         w_nib[5] = year_l[7:4];
         w_nib[4] = year_l[3:0];
         w_nib[3] = {3'b000, month[4]};
         w_nib[2] = month[3:0];
         w_nib[1] = {2'b00, day[5:4]};
         w_nib[0] = day[3:0];
      end else begin
         w_nib[7] = {2'b00, hour[5:4]};
         w_nib[6] = hour[3:0];
         w_nib[5] = {1'b0, minute[6:4]};
         w_nib[4] = minute[3:0];
         w_nib[3] = {1'b0, second[6:4]};
         w_nib[2] = second[3:0];
         w_nib[1] = millisecond[7:4];
         w_nib[0] = millisecond[3:0];
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_digit
      localparam logic [2:0] C_IDX = 3'(i);
      bcd_to_seg7 u_dec (
         .bcd (w_nib[i]),
         .seg (w_seg[i])
      );
      assign w_blank[i] = ~adjust & ~w_blink_nxt & (select[2:0] == C_IDX);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state       <= SHOW_TIME;
         r_presc       <= '0;
         r_blink_on    <= 1'b1;
         r_tmo         <= '0;
         r_key_prev    <= 1'b0;
         r_adjust_prev <= 1'b0;
         r_select_prev <= 4'd0;
         r_page        <= 1'b0;
         for (int i = 0; i < 8; i++) r_hex[i] <= C_SEG_BLANK;
      end else begin
         r_state       <= w_state_nxt;
         r_presc       <= w_presc_nxt;
         r_blink_on    <= w_blink_nxt;
         r_tmo         <= w_tmo_nxt;
         r_key_prev    <= page_key;
         r_adjust_prev <= adjust;
         r_select_prev <= select;
         r_page        <= w_page_nxt;
         for (int i = 0; i < 8; i++) r_hex[i] <= w_blank[i] ? C_SEG_BLANK : w_seg[i];
      end
   end

   assign HEX0 = r_hex[0];
   assign HEX1 = r_hex[1];
   assign HEX2 = r_hex[2];
   assign HEX3 = r_hex[3];
   assign HEX4 = r_hex[4];
   assign HEX5 = r_hex[5];
   assign HEX6 = r_hex[6];
   assign HEX7 = r_hex[7];
   assign page = r_page;

endmodule

`default_nettype wire
